// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: an FF46 write copies LEN bytes from {src_hi,00} into OAM, one byte per clk.
// First OAM write START_DELAY+2 clks after the trigger; no backpressure, the source answers in one clk.
module oam_dma_ctrl #(
    parameter int LEN         = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  reg_out,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_rd_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_write,
    output logic        busy
);
    localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
    localparam logic [1:0] DELAY_INIT = 2'(START_DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_reg;
    logic [7:0] r_src_hi;
    logic [7:0] r_idx;
    logic [7:0] r_oam_idx;
    logic [1:0] r_delay;
    logic       r_vld;
    logic       w_trig;
    logic       w_last;
    logic [7:0] w_mapped_hi;

    assign w_trig      = cpu_write && (cpu_addr == 16'hFF46);
    assign w_last      = (r_idx == LAST_IDX);
    // Echo RAM E000..FFFF reads back work RAM C000..DFFF.
    assign w_mapped_hi = (r_src_hi >= 8'hE0) ? (r_src_hi - 8'h20) : r_src_hi;

    always_comb begin
        w_next = r_state;
        if (w_trig) begin
            w_next = START;
        end else begin
            unique case (r_state)
                IDLE:  w_next = IDLE;
                START: if (r_delay == 2'd0) w_next = XFER;
                XFER:  if (w_last) w_next = DRAIN;
                DRAIN: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg     <= 8'h00;
            r_src_hi  <= 8'h00;
            r_idx     <= 8'h00;
            r_oam_idx <= 8'h00;
            r_delay   <= 2'd0;
            r_vld     <= 1'b0;
        end else begin
            // The read issued this cycle always lands, even across a restart.
            r_vld     <= (r_state == XFER);
            r_oam_idx <= r_idx;
            if (w_trig) begin
                r_reg    <= cpu_d_out;
                r_src_hi <= cpu_d_out;
                r_idx    <= 8'h00;
                r_delay  <= DELAY_INIT;
            end else if (r_state == START) begin
                if (r_delay != 2'd0) r_delay <= r_delay - 2'd1;
            end else if (r_state == XFER) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    assign reg_out   = r_reg;
    assign busy      = (r_state != IDLE);
    assign bus_grant = (r_state == XFER);
    assign dma_addr  = bus_grant ? {w_mapped_hi, r_idx} : 16'h0000;
    assign oam_write = r_vld;
    assign oam_addr  = r_vld ? r_oam_idx : 8'h00;
    assign oam_data  = r_vld ? dma_rd_data : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: per-cycle comparison against a timeline model plus directed literal checks.
module tb_oam_dma_ctrl;
    localparam int LEN = 160;
    localparam int D   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  reg_out;
    logic        bus_grant;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rd_data = 8'h00;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_write;
    logic        busy;

    oam_dma_ctrl #(.LEN(LEN), .START_DELAY(D)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
        .cpu_write(cpu_write), .reg_out(reg_out), .bus_grant(bus_grant),
        .dma_addr(dma_addr), .dma_rd_data(dma_rd_data), .oam_addr(oam_addr),
        .oam_data(oam_data), .oam_write(oam_write), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source memory contents: byte at address a is lo^hi^9B, so page C1 holds i^5A.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9B;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] hi);
        return (hi >= 8'hE0) ? hi - 8'h20 : hi;
    endfunction

    always @(posedge clk) dma_rd_data <= src_byte(dma_addr);

    // Timeline model: a transfer started in cycle t0 reads byte k in cycle t0+D+1+k,
    // writes it one cycle later, and stays busy through the last write.
    typedef struct packed {
        logic       act;
        int         start;
        int         cyc;
        logic [7:0] src;
        logic [7:0] reg_v;
        logic       iss;
        logic [7:0] iss_idx;
        logic       wr;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       busy;
    } mdl_t;

    function automatic mdl_t step(input mdl_t m, input logic trig, input logic [7:0] d);
        mdl_t n;
        int   off;
        n       = m;
        n.cyc   = m.cyc + 1;
        n.wr    = m.iss;
        n.waddr = m.iss_idx;
        n.wdata = src_byte({fold(m.src), m.iss_idx});
        if (trig) begin
            n.act   = 1'b1;
            n.start = n.cyc;
            n.src   = d;
            n.reg_v = d;
        end
        off       = n.cyc - n.start;
        n.iss     = n.act && (off >= D + 1) && (off < D + 1 + LEN);
        n.iss_idx = 8'(off - (D + 1));
        n.busy    = n.act && (off <= D + 1 + LEN);
        if (!n.busy) n.act = 1'b0;
        return n;
    endfunction

    mdl_t m = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= step(m, cpu_write && (cpu_addr == 16'hFF46), cpu_d_out);
    end

    logic [7:0] oam_img [256];

    always @(negedge clk) begin
        check("reg_out",   32'(reg_out),   32'(m.reg_v));
        check("busy",      32'(busy),      32'(m.busy));
        check("bus_grant", 32'(bus_grant), 32'(m.iss));
        check("dma_addr",  32'(dma_addr),  32'(m.iss ? {fold(m.src), m.iss_idx} : 16'h0000));
        check("oam_write", 32'(oam_write), 32'(m.wr));
        check("oam_addr",  32'(oam_addr),  32'(m.wr ? m.waddr : 8'h00));
        check("oam_data",  32'(oam_data),  32'(m.wr ? m.wdata : 8'h00));
        if (oam_write) oam_img[oam_addr] = oam_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] v);
        cpu_addr  = a;
        cpu_d_out = v;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_d_out = 8'h00;
    endtask

    int         x_first, x_bend, x_grants, x_writes;
    logic [15:0] g_first_addr, g_last_addr;

    // Observe one transfer from cycle n0 (cycle 0 = the one right after the trigger edge).
    task automatic measure(input int n0, input bit stray);
        x_first = -1; x_bend = -1; x_grants = 0; x_writes = 0;
        g_first_addr = 16'h0000; g_last_addr = 16'h0000;
        for (int n = n0; n < 400; n++) begin
            if (oam_write) begin
                if (x_first < 0) x_first = n;
                x_writes++;
            end
            if (bus_grant) begin
                if (x_grants == 0) g_first_addr = dma_addr;
                g_last_addr = dma_addr;
                x_grants++;
            end
            if (!busy) begin
                x_bend = n;
                break;
            end
            if (stray && (n == 40 || n == 41)) begin
                cpu_addr  = (n == 40) ? 16'hFF45 : 16'hFF47;
                cpu_d_out = 8'h33;
                cpu_write = 1'b1;
            end
            tick();
            cpu_write = 1'b0;
            cpu_addr  = 16'h0000;
        end
        check("xfer_completes", 32'(x_bend >= 0), 1);
    endtask

    task automatic run_xfer(input logic [7:0] v, input bit stray);
        cpu_wr(16'hFF46, v);
        check("reg_out_next_clk", 32'(reg_out), 32'(v));
        measure(0, stray);
        check("first_write_cycle", x_first, 3);
        check("busy_low_cycle", x_bend, 163);
        check("grant_cycles", x_grants, 160);
        check("write_count", x_writes, 160);
    endtask

    initial begin
        int bad;
        int seen;
        int found;
        rst = 1'b1; cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_write = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_reg_out",   32'(reg_out),   0);
        check("rst_busy",      32'(busy),      0);
        check("rst_bus_grant", 32'(bus_grant), 0);
        check("rst_oam_write", 32'(oam_write), 0);
        check("rst_dma_addr",  32'(dma_addr),  0);
        check("rst_oam_addr",  32'(oam_addr),  0);
        check("rst_oam_data",  32'(oam_data),  0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Readback of the written value, held after the transfer.
        run_xfer(8'h80, 1'b0);
        check("reg_out_held", 32'(reg_out), 'h80);

        // Basic copy from C100.
        run_xfer(8'hC1, 1'b0);
        check("oam0_c1",   32'(oam_img[0]),   'h5A);
        check("oam159_c1", 32'(oam_img[159]), 'hC5);
        bad = 0;
        for (int i = 0; i < LEN; i++) if (oam_img[i] !== (8'(i) ^ 8'h5A)) bad++;
        check("oam_image_c1", bad, 0);

        // Writes to neighbouring registers are ignored, idle and mid-transfer.
        cpu_wr(16'hFF45, 8'h11);
        cpu_wr(16'hFF47, 8'h22);
        check("stray_idle_busy",    32'(busy),    0);
        check("stray_idle_reg_out", 32'(reg_out), 'hC1);
        run_xfer(8'hC4, 1'b1);
        check("stray_xfer_reg_out", 32'(reg_out), 'hC4);

        // Echo page folds down to work RAM.
        run_xfer(8'hE2, 1'b0);
        check("echo_first_addr", 32'(g_first_addr), 'hC200);
        check("echo_last_addr",  32'(g_last_addr),  'hC29F);

        // Restart while write 48 is visible: read 49 is in flight and must still land.
        cpu_wr(16'hFF46, 8'hC1);
        seen = 0; found = 0;
        for (int n = 0; n < 300 && found == 0; n++) begin
            if (oam_write) begin
                seen++;
                if (oam_addr == 8'd48) found = 1;
            end
            if (found == 0) tick();
        end
        check("restart_reached_48", found, 1);
        check("restart_writes_before", seen, 49);
        cpu_wr(16'hFF46, 8'hD0);
        check("inflight_write", 32'(oam_write), 1);
        check("inflight_addr",  32'(oam_addr),  49);
        check("inflight_data",  32'(oam_data),  'h6B);
        tick();
        measure(1, 1'b0);
        check("restart_first_write", x_first, 3);
        check("restart_busy_low", x_bend, 163);
        check("restart_write_count", x_writes, 160);
        check("oam0_d0",  32'(oam_img[0]),  'h4B);
        check("oam49_d0", 32'(oam_img[49]), 'h7A);
        bad = 0;
        for (int i = 0; i < LEN; i++) if (oam_img[i] !== (8'(i) ^ 8'h4B)) bad++;
        check("oam_image_d0", bad, 0);

        // Reset in the middle of a transfer.
        cpu_wr(16'hFF46, 8'hC3);
        repeat (20) tick();
        check("pre_reset_grant", 32'(bus_grant), 1);
        rst = 1'b0;
        #1;
        check("midrst_busy",      32'(busy),      0);
        check("midrst_bus_grant", 32'(bus_grant), 0);
        check("midrst_oam_write", 32'(oam_write), 0);
        check("midrst_dma_addr",  32'(dma_addr),  0);
        check("midrst_reg_out",   32'(reg_out),   0);
        repeat (2) tick();
        rst = 1'b1;
        seen = 0; found = 0;
        for (int n = 0; n < 200; n++) begin
            if (oam_write) seen++;
            if (busy) found++;
            tick();
        end
        check("post_reset_writes", seen, 0);
        check("post_reset_busy", found, 0);
        check("post_reset_reg_out", 32'(reg_out), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
